// File: rtl/quad_pkg.sv
// Shared quadrature definitions so the generator and the decoder agree on
// widths, FSM states and the phase-to-(A,B) encoding.
package quad_pkg;

   localparam int unsigned QuadCntW = 16;
   localparam int unsigned QuadDivW = 16;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StFinish = 2'd2
   } quad_state_e;

   // {A,B} per phase; stepping the phase by one toggles exactly one channel.
   localparam logic [1:0] QuadAbPh0 = 2'b00;
   localparam logic [1:0] QuadAbPh1 = 2'b10;
   localparam logic [1:0] QuadAbPh2 = 2'b11;
   localparam logic [1:0] QuadAbPh3 = 2'b01;

   function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
      logic [1:0] ab;
      unique case (phase)
         2'd0:    ab = QuadAbPh0;
         2'd1:    ab = QuadAbPh1;
         2'd2:    ab = QuadAbPh2;
         default: ab = QuadAbPh3;
      endcase
      return ab;
   endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Edge-rate divider: counts 1..period while enabled, restarting at 1 on start_i
// or after reaching period; tc_o requests an edge.
module quad_step_timer
   import quad_pkg::*;
#(
   parameter int unsigned DIV_W = QuadDivW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] period_i,
   output logic             tc_o
);

   logic [DIV_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = DIV_W'(1);
      end else if (en_i) begin
         cnt_d = (cnt_q >= period_i) ? DIV_W'(1) : cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires one cycle early: the registered edge then lands as the count reaches period.
   assign tc_o = en_i && (cnt_q == period_i - DIV_W'(1));

endmodule

// File: rtl/quad_gen.sv
// Quadrature stimulus generator: turns signed step commands into A/B edges at a
// programmable rate and tracks position. Define QUAD_GEN_INDEX_EN for the index output.
module quad_gen
   import quad_pkg::*;
#(
   parameter int unsigned CNT_W      = QuadCntW,
   parameter int unsigned DIV_W      = QuadDivW,
   parameter int unsigned MIN_PERIOD = 2
`ifdef QUAD_GEN_INDEX_EN
   ,
   parameter int unsigned IDX_PERIOD = 1024
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [CNT_W-1:0] cmd_steps_i,
   input  logic [DIV_W-1:0] cmd_period_i,
   input  logic             abort_i,
   input  logic             pos_clr_i,
   output logic             quad_a_o,
   output logic             quad_b_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] position_o
`ifdef QUAD_GEN_INDEX_EN
   ,
   output logic             index_o
`endif
);

   quad_state_e      state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] pos_q, pos_d;
   logic [DIV_W-1:0] per_q, per_d;
   logic             dir_q, dir_d;
   logic [1:0]       phase_q, phase_d;
   logic [1:0]       ab_q;
   logic [CNT_W-1:0] steps_abs;
   logic             steps_zero;
   logic             accept;
   logic             tick;
   logic             edge_en;

   // Unsigned magnitude: the most negative command maps to 2^(CNT_W-1).
   assign steps_abs  = cmd_steps_i[CNT_W-1] ? (~cmd_steps_i + CNT_W'(1)) : cmd_steps_i;
   assign steps_zero = (cmd_steps_i == '0);
   assign accept     = cmd_valid_i && cmd_ready_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = steps_zero ? StFinish : StRun;
         end
         StRun: begin
            if (abort_i || (rem_q == '0)) state_d = StFinish;
         end
         StFinish: begin
            if (accept) state_d = steps_zero ? StFinish : StRun;
            else        state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready_o = (state_q != StRun);
      busy_o      = (state_q == StRun);
      done_o      = (state_q == StFinish);
   end

   quad_step_timer #(
      .DIV_W (DIV_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (accept),
      .en_i     (busy_o),
      .period_i (per_q),
      .tc_o     (tick)
   );

   assign edge_en = busy_o && tick && !abort_i && (rem_q != '0);

   always_comb begin
      rem_d   = rem_q;
      dir_d   = dir_q;
      per_d   = per_q;
      phase_d = phase_q;
      pos_d   = pos_q;
      if (accept) begin
         rem_d = steps_abs;
         dir_d = cmd_steps_i[CNT_W-1];
         per_d = (cmd_period_i < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : cmd_period_i;
      end
      if (edge_en) begin
         rem_d   = rem_q - CNT_W'(1);
         phase_d = dir_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
         pos_d   = dir_q ? (pos_q - CNT_W'(1)) : (pos_q + CNT_W'(1));
      end
      if (pos_clr_i) pos_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q   <= '0;
         dir_q   <= 1'b0;
         per_q   <= DIV_W'(MIN_PERIOD);
         phase_q <= 2'd0;
         pos_q   <= '0;
         ab_q    <= QuadAbPh0;
      end else begin
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         per_q   <= per_d;
         phase_q <= phase_d;
         pos_q   <= pos_d;
         ab_q    <= phase_to_ab(phase_d);
      end
   end

   assign quad_a_o   = ab_q[1];
   assign quad_b_o   = ab_q[0];
   assign position_o = pos_q;

`ifdef QUAD_GEN_INDEX_EN
   localparam int unsigned IdxW = $clog2(IDX_PERIOD);

   logic index_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_q <= 1'b0;
      end else begin
         index_q <= (pos_d[IdxW-1:0] == '0);
      end
   end

   assign index_o = index_q;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// Directed bench for quad_gen: an edge-schedule model checked every cycle plus
// hand-computed spot checks and a behavioural quadrature decoder in loopback.
module tb_quad_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_steps;
   logic [15:0] cmd_period;
   logic        abort;
   logic        pos_clr;
   logic        quad_a;
   logic        quad_b;
   logic        busy;
   logic        done;
   logic [15:0] position;
`ifdef QUAD_GEN_INDEX_EN
   logic        index;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   quad_gen #(
      .CNT_W      (16),
      .DIV_W      (16),
      .MIN_PERIOD (2)
`ifdef QUAD_GEN_INDEX_EN
      ,
      .IDX_PERIOD (4)
`endif
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_steps_i  (cmd_steps),
      .cmd_period_i (cmd_period),
      .abort_i      (abort),
      .pos_clr_i    (pos_clr),
      .quad_a_o     (quad_a),
      .quad_b_o     (quad_b),
      .busy_o       (busy),
      .done_o       (done),
      .position_o   (position)
`ifdef QUAD_GEN_INDEX_EN
      ,
      .index_o      (index)
`endif
   );

   // Model: (A,B) per phase and the active command's edge schedule.
   logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   int          n;
   int          m_t, m_n, m_p, m_dir, m_cnt;
   int          e_phase;
   logic [15:0] e_pos;
   bit          e_busy, e_done, e_idx;
   int          dec_cnt, dec_prev;

   task automatic model_reset();
      e_phase = 0; e_pos = '0; e_busy = 0; e_done = 0; e_idx = 0;
      m_t = 0; m_n = 0; m_p = 2; m_dir = 1; m_cnt = 0;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, n);
      end
   endtask

   function automatic int ab_to_ph(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Advance one clock; the model consumes the inputs that were present in the prior cycle.
   task automatic cyc();
      logic        v   = cmd_valid;
      logic [15:0] st  = cmd_steps;
      logic [15:0] pr  = cmd_period;
      logic        ab  = abort;
      logic        clr = pos_clr;
      bit          run_prev = e_busy;
      bit          edge_now = 0;
      bit          dn = 0;
      bit          bs = 0;
      int          s;
      int          d;
      @(posedge clk);
      #1;
      n++;
      if (run_prev) begin
         if (ab) begin
            dn = 1;
         end else begin
            if (((n - m_t) % m_p == 0) && (m_cnt < m_n)) edge_now = 1;
            if (n == m_t + m_n * m_p + 1) dn = 1;
            else bs = 1;
         end
      end else if (v) begin
         s     = int'($signed(st));
         m_t   = n - 1;
         m_n   = (s < 0) ? -s : s;
         m_p   = (int'(pr) < 2) ? 2 : int'(pr);
         m_dir = (s < 0) ? -1 : 1;
         m_cnt = 0;
         if (m_n == 0) dn = 1;
         else bs = 1;
      end
      if (edge_now) begin
         m_cnt++;
         e_phase = (e_phase + m_dir + 4) % 4;
         e_pos   = (m_dir > 0) ? e_pos + 16'd1 : e_pos - 16'd1;
      end
      if (clr) e_pos = '0;
      e_busy = bs;
      e_done = dn;
      e_idx  = (e_pos[1:0] == 2'b00);
      // Every-cycle comparison of all outputs against the model.
      tests++;
      if ({quad_a, quad_b} !== ab_tab[e_phase] || position !== e_pos || busy !== e_busy ||
          done !== e_done || cmd_ready !== !e_busy
`ifdef QUAD_GEN_INDEX_EN
          || index !== e_idx
`endif
         ) begin
         fails++;
         $display("FAIL cycle %0d: got ab=%b pos=%0h busy=%b done=%b rdy=%b, expected ab=%b pos=%0h busy=%b done=%b rdy=%b",
                  n, {quad_a, quad_b}, position, busy, done, cmd_ready,
                  ab_tab[e_phase], e_pos, e_busy, e_done, !e_busy);
      end
      // Loopback decoder.
      d = (ab_to_ph({quad_a, quad_b}) - dec_prev + 4) % 4;
      if (d == 1) dec_cnt++;
      else if (d == 3) dec_cnt--;
      dec_prev = ab_to_ph({quad_a, quad_b});
   endtask

   task automatic wait_to(input int t);
      while (n < t) cyc();
   endtask

   task automatic wait_done(input string name, input int limit);
      int k = 0;
      while (done !== 1'b1 && k < limit) begin
         cyc();
         k++;
      end
      check(name, 32'(done), 32'd1);
   endtask

   // Fields are scrambled after acceptance: they must not be re-sampled.
   task automatic issue(input int steps, input int per, output int t);
      cmd_valid  = 1'b1;
      cmd_steps  = 16'(steps);
      cmd_period = 16'(per);
      t = n;
      cyc();
      cmd_valid  = 1'b0;
      cmd_steps  = 16'h5a5a;
      cmd_period = 16'd1;
   endtask

   task automatic clr_pos();
      pos_clr = 1'b1;
      cyc();
      pos_clr = 1'b0;
      cyc();
   endtask

   initial begin
      int t;
      int d0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_period = '0;
      abort = 1'b0; pos_clr = 1'b0;
      n = 0; dec_cnt = 0; dec_prev = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset ab", 32'({quad_a, quad_b}), 32'd0);
      check("reset pos", 32'(position), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset ready", 32'(cmd_ready), 32'd1);
`ifdef QUAD_GEN_INDEX_EN
      check("reset index", 32'(index), 32'd0);
`endif
      rst_n = 1'b1;
      cyc(); cyc();

      // +4 steps, period 3
      issue(4, 3, t);
      wait_to(t + 3);  check("t1 e1", 32'({quad_a, quad_b}), 32'b10);
      wait_to(t + 6);  check("t1 e2", 32'({quad_a, quad_b}), 32'b11);
      wait_to(t + 9);  check("t1 e3", 32'({quad_a, quad_b}), 32'b01);
      wait_to(t + 12); check("t1 e4", 32'({quad_a, quad_b}), 32'b00);
      check("t1 pos", 32'(position), 32'd4);
      wait_to(t + 13); check("t1 done", 32'(done), 32'd1);

      // -3 steps, period 5, from phase 0
      clr_pos();
      issue(-3, 5, t);
      wait_to(t + 5);  check("t2 e1", 32'({quad_a, quad_b}), 32'b01);
      wait_to(t + 10); check("t2 e2", 32'({quad_a, quad_b}), 32'b11);
      wait_to(t + 15); check("t2 e3", 32'({quad_a, quad_b}), 32'b10);
      check("t2 pos", 32'(position), 32'h0000fffd);
      wait_to(t + 16); check("t2 done", 32'(done), 32'd1);

      // Accepted despite abort in IDLE; returns phase to 0
      abort = 1'b1;
      issue(3, 2, t);
      abort = 1'b0;
      wait_done("t3 done", 20);

      // Abort mid-run after two edges
      clr_pos();
      issue(10, 4, t);
      wait_to(t + 9);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check("t4 done", 32'(done), 32'd1);
      check("t4 pos", 32'(position), 32'd2);
      check("t4 ab", 32'({quad_a, quad_b}), 32'b11);
      wait_to(t + 14);
      check("t4 hold", 32'({quad_a, quad_b}), 32'b11);

      // Period 0 clamps to 2
      issue(2, 0, t);
      wait_to(t + 2); check("t5 e1", 32'({quad_a, quad_b}), 32'b01);
      wait_to(t + 3); check("t5 gap", 32'({quad_a, quad_b}), 32'b01);
      wait_to(t + 4); check("t5 e2", 32'({quad_a, quad_b}), 32'b00);
      wait_to(t + 5); check("t5 done", 32'(done), 32'd1);

      // Most negative step count runs (not treated as zero), then aborted
      issue(-32768, 2, t);
      wait_to(t + 1); check("neg busy", 32'(busy), 32'd1);
      wait_to(t + 6); check("neg pos", 32'(position), 32'd1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      cyc();

      // Loopback, back-to-back commands
      clr_pos();
      d0 = dec_cnt;
      issue(100, 2, t);
      wait_done("lb fwd done", 300);
      issue(-40, 3, t);
      wait_done("lb rev done", 200);
      check("lb decoder", 32'(dec_cnt - d0), 32'd60);
      check("lb pos", 32'(position), 32'd60);

      // pos_clr coinciding with an edge wins
      issue(2, 3, t);
      wait_to(t + 5);
      pos_clr = 1'b1;
      cyc();
      pos_clr = 1'b0;
      check("clr edge pos", 32'(position), 32'd0);
      wait_to(t + 7);
      check("clr done", 32'(done), 32'd1);
      check("clr final pos", 32'(position), 32'd0);

`ifdef QUAD_GEN_INDEX_EN
      clr_pos();
      issue(8, 2, t);
      wait_to(t + 1);  check("idx p0", 32'(index), 32'd1);
      wait_to(t + 8);  check("idx p4", 32'(index), 32'd1);
      wait_to(t + 10); check("idx p5", 32'(index), 32'd0);
      wait_to(t + 16); check("idx p8", 32'(index), 32'd1);
      check("idx pos", 32'(position), 32'd8);
      wait_done("idx done", 10);
`endif

      // Async reset mid-run
      issue(5, 4, t);
      wait_to(t + 6);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst ab", 32'({quad_a, quad_b}), 32'd0);
      check("arst pos", 32'(position), 32'd0);
      check("arst busy", 32'(busy), 32'd0);
      check("arst done", 32'(done), 32'd0);
      check("arst ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      dec_prev = 0;
      repeat (4) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
